// File: rtl/monocycle_pkg.sv
// Shared constants and types for the single-cycle RV32I core:
// opcodes, funct3 codes, ALU/immediate selectors and decode helpers.
package monocycle_pkg;

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam logic [2:0] F3_SB = 3'd0;
    localparam logic [2:0] F3_SH = 3'd1;
    localparam logic [2:0] F3_SW = 3'd2;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_sel_t;

    typedef enum logic [1:0] {
        WB_ALU, WB_MEM, WB_LINK
    } wb_sel_t;

    function automatic logic [31:0] imm_gen(input logic [31:0] i,
                                            input imm_sel_t s);
        logic [31:0] r;
        unique case (s)
            IMM_I:   r = {{20{i[31]}}, i[31:20]};
            IMM_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   r = {{19{i[31]}}, i[31], i[7], i[30:25],
                          i[11:8], 1'b0};
            IMM_U:   r = {i[31:12], 12'b0};
            IMM_J:   r = {{11{i[31]}}, i[31], i[19:12], i[20],
                          i[30:21], 1'b0};
            default: r = '0;
        endcase
        return r;
    endfunction

    // alt selects SUB/SRA; caller masks it for OP-IMM non-shifts
    function automatic alu_op_t alu_dec(input logic [2:0] f3,
                                        input logic alt);
        alu_op_t op;
        unique case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two combinational reads, one synchronous write.
// Ports: clk_i, rst_ni, we_i/waddr_i/wdata_i, raddr1_i/2_i -> rdata1_o/2_o.
module register_file (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o
);

    logic [31:0] memory [0:31];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                memory[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            memory[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == 5'd0) ? '0 : memory[raddr1_i];
    assign rdata2_o = (raddr2_i == 5'd0) ? '0 : memory[raddr2_i];

endmodule

// File: rtl/monocycle_processor.sv
// Single-cycle RV32I core with word-addressed IM and DM. Ports: clk, rst
// (async active-low). MONOCYCLE_BYTE_HALF_EN adds LB/LH/LBU/LHU/SB/SH.
module monocycle_processor
    import monocycle_pkg::*;
#(
    parameter int          IMEM_WORDS = 256,
    parameter int          DMEM_WORDS = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input logic clk,
    input logic rst
);

    localparam int IAW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam int DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_out;
    logic [31:0] instruction;

    assign pc_out = pc_q;

    if (1) begin : IM
        logic [31:0] mem [0:IMEM_WORDS-1];
        logic [29:0] idx;
        assign idx = pc_out[31:2];
        assign instruction = (idx < 30'(IMEM_WORDS))
                           ? mem[idx[IAW-1:0]] : NOP_INSN;
    end

    logic [6:0] opc;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;

    assign opc = instruction[6:0];
    assign rd  = instruction[11:7];
    assign f3  = instruction[14:12];
    assign rs1 = instruction[19:15];
    assign rs2 = instruction[24:20];

    logic        rf_we, dm_we_dec;
    logic        is_br, is_jal, is_jalr;
    logic        a_pc, b_imm;
    logic        ld_ok, st_ok;
    imm_sel_t    imm_sel;
    alu_op_t     alu_op;
    wb_sel_t     wb_sel;

`ifdef MONOCYCLE_BYTE_HALF_EN
    assign ld_ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                   (f3 == F3_LBU) || (f3 == F3_LHU);
    assign st_ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
`else
    assign ld_ok = (f3 == F3_LW);
    assign st_ok = (f3 == F3_SW);
`endif

    always_comb begin
        rf_we     = 1'b0;
        dm_we_dec = 1'b0;
        is_br     = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        a_pc      = 1'b0;
        b_imm     = 1'b0;
        imm_sel   = IMM_I;
        alu_op    = ALU_ADD;
        wb_sel    = WB_ALU;
        unique case (1'b1)
            (opc == OPC_LUI): begin
                rf_we   = 1'b1;
                imm_sel = IMM_U;
                b_imm   = 1'b1;
                alu_op  = ALU_PASSB;
            end
            (opc == OPC_AUIPC): begin
                rf_we   = 1'b1;
                imm_sel = IMM_U;
                a_pc    = 1'b1;
                b_imm   = 1'b1;
            end
            (opc == OPC_JAL): begin
                rf_we   = 1'b1;
                is_jal  = 1'b1;
                imm_sel = IMM_J;
                wb_sel  = WB_LINK;
            end
            (opc == OPC_JALR): begin
                rf_we   = (f3 == 3'd0);
                is_jalr = (f3 == 3'd0);
                b_imm   = 1'b1;
                wb_sel  = WB_LINK;
            end
            (opc == OPC_BRANCH): begin
                // funct3 2/3 are reserved and fall through as NOP
                is_br   = (f3 != 3'd2) && (f3 != 3'd3);
                imm_sel = IMM_B;
            end
            (opc == OPC_LOAD): begin
                rf_we  = ld_ok;
                b_imm  = 1'b1;
                wb_sel = WB_MEM;
            end
            (opc == OPC_STORE): begin
                dm_we_dec = st_ok;
                imm_sel   = IMM_S;
                b_imm     = 1'b1;
            end
            (opc == OPC_OP_IMM): begin
                rf_we  = 1'b1;
                b_imm  = 1'b1;
                // bit 30 is immediate data except for SRAI
                alu_op = alu_dec(f3, (f3 == F3_SR) && instruction[30]);
            end
            (opc == OPC_OP): begin
                rf_we  = 1'b1;
                alu_op = alu_dec(f3, instruction[30]);
            end
            default: ;
        endcase
    end

    logic [31:0] imm;
    logic [31:0] rs1_v, rs2_v;
    logic [31:0] wb_data;

    assign imm = imm_gen(instruction, imm_sel);

    register_file RF (
        .clk_i    (clk),
        .rst_ni   (rst),
        .we_i     (rf_we),
        .waddr_i  (rd),
        .wdata_i  (wb_data),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (rs1_v),
        .rdata2_o (rs2_v)
    );

    logic [31:0] alu_a, alu_b, alu_y;
    logic [4:0]  shamt;

    assign alu_a = a_pc ? pc_out : rs1_v;
    assign alu_b = b_imm ? imm : rs2_v;
    assign shamt = alu_b[4:0];

    always_comb begin
        alu_y = '0;
        unique case (alu_op)
            ALU_ADD:   alu_y = alu_a + alu_b;
            ALU_SUB:   alu_y = alu_a - alu_b;
            ALU_SLL:   alu_y = alu_a << shamt;
            ALU_SLT:   alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU:  alu_y = {31'd0, alu_a < alu_b};
            ALU_XOR:   alu_y = alu_a ^ alu_b;
            ALU_SRL:   alu_y = alu_a >> shamt;
            ALU_SRA:   alu_y = $unsigned($signed(alu_a) >>> shamt);
            ALU_OR:    alu_y = alu_a | alu_b;
            ALU_AND:   alu_y = alu_a & alu_b;
            ALU_PASSB: alu_y = alu_b;
            default:   alu_y = '0;
        endcase
    end

    logic br_cond, br_taken;

    always_comb begin
        br_cond = 1'b0;
        unique case (f3)
            F3_BEQ:  br_cond = (rs1_v == rs2_v);
            F3_BNE:  br_cond = (rs1_v != rs2_v);
            F3_BLT:  br_cond = $signed(rs1_v) < $signed(rs2_v);
            F3_BGE:  br_cond = !($signed(rs1_v) < $signed(rs2_v));
            F3_BLTU: br_cond = (rs1_v < rs2_v);
            F3_BGEU: br_cond = !(rs1_v < rs2_v);
            default: br_cond = 1'b0;
        endcase
    end

    assign br_taken = is_br && br_cond;

    logic [31:0] pc_plus4, pc_imm;

    assign pc_plus4 = pc_out + 32'd4;
    assign pc_imm   = pc_out + imm;

    always_comb begin
        pc_d = pc_plus4;
        if (is_jalr) begin
            pc_d = {alu_y[31:1], 1'b0};
        end else if (is_jal || br_taken) begin
            pc_d = pc_imm;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    logic [29:0] dm_idx;
    logic        dm_in, dm_we;
    logic [31:0] dm_rdata, dm_wdata, ld_data;

    assign dm_idx = alu_y[31:2];
    assign dm_in  = (dm_idx < 30'(DMEM_WORDS));
    assign dm_we  = dm_we_dec;

    if (1) begin : DM
        logic [31:0] mem [0:DMEM_WORDS-1];
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < DMEM_WORDS; i++) begin
                    mem[i] <= '0;
                end
            end else if (dm_we && dm_in) begin
                mem[dm_idx[DAW-1:0]] <= dm_wdata;
            end
        end
        assign dm_rdata = dm_in ? mem[dm_idx[DAW-1:0]] : '0;
    end

`ifdef MONOCYCLE_BYTE_HALF_EN
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [3:0]  st_be;
    logic [31:0] st_data;

    assign ld_byte = dm_rdata[{alu_y[1:0], 3'b000} +: 8];
    // odd halfword addresses still pick the lane from addr[1]
    assign ld_half = alu_y[1] ? dm_rdata[31:16] : dm_rdata[15:0];

    always_comb begin
        ld_data = dm_rdata;
        unique case (f3)
            F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_LBU:  ld_data = {24'd0, ld_byte};
            F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            F3_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = dm_rdata;
        endcase
    end

    always_comb begin
        st_be   = 4'b1111;
        st_data = rs2_v;
        unique case (f3)
            F3_SB: begin
                st_be   = 4'b0001 << alu_y[1:0];
                st_data = {4{rs2_v[7:0]}};
            end
            F3_SH: begin
                st_be   = alu_y[1] ? 4'b1100 : 4'b0011;
                st_data = {2{rs2_v[15:0]}};
            end
            default: ;
        endcase
    end

    // read-modify-write: untouched lanes keep the old word
    always_comb begin
        dm_wdata = dm_rdata;
        for (int k = 0; k < 4; k++) begin
            if (st_be[k]) begin
                dm_wdata[8*k +: 8] = st_data[8*k +: 8];
            end
        end
    end
`else
    logic unused_addr_lo;

    assign unused_addr_lo = ^alu_y[1:0];
    assign ld_data        = dm_rdata;
    assign dm_wdata       = rs2_v;
`endif

    always_comb begin
        wb_data = alu_y;
        unique case (wb_sel)
            WB_MEM:  wb_data = ld_data;
            WB_LINK: wb_data = pc_plus4;
            default: wb_data = alu_y;
        endcase
    end

endmodule

// File: tb/tb_monocycle_processor.sv
// Bench for monocycle_processor: trace table of instructions with
// expected PC/register/memory results, plus reset corner sequences.
module tb_monocycle_processor;
    import monocycle_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    monocycle_processor #(
        .IMEM_WORDS (256),
        .DMEM_WORDS (64),
        .RESET_PC   (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst)
    );

    always #5 clk = ~clk;

    localparam int K_REG = 0;
    localparam int K_MEM = 1;
    localparam int K_PC  = 2;

    typedef struct {
        string       name;
        logic [31:0] insn;
        int          kind;
        int          idx;
        logic [31:0] val;
        logic [31:0] npc;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [31:0] enc_i(logic [31:0] imm, logic [31:0] r1,
                                          logic [31:0] f3, logic [31:0] rd,
                                          logic [31:0] op);
        return {imm[11:0], r1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_r(logic [31:0] f7, logic [31:0] r2,
                                          logic [31:0] r1, logic [31:0] f3,
                                          logic [31:0] rd);
        return {f7[6:0], r2[4:0], r1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(logic [31:0] imm, logic [31:0] r2,
                                          logic [31:0] r1, logic [31:0] f3);
        return {imm[11:5], r2[4:0], r1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(logic [31:0] imm, logic [31:0] r2,
                                          logic [31:0] r1, logic [31:0] f3);
        return {imm[12], imm[10:5], r2[4:0], r1[4:0], f3[2:0],
                imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(logic [31:0] imm, logic [31:0] rd,
                                          logic [31:0] op);
        return {imm[19:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_j(logic [31:0] imm, logic [31:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
    endfunction

    function automatic vec_t mk(string n, logic [31:0] insn, int kind,
                                int idx, logic [31:0] val,
                                logic [31:0] npc);
        vec_t v;
        v.name = n;
        v.insn = insn;
        v.kind = kind;
        v.idx  = idx;
        v.val  = val;
        v.npc  = npc;
        return v;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h", n, act, exp);
        end
    endtask

    task automatic chk_all_zero(string n);
        logic [31:0] rf_acc;
        logic [31:0] dm_acc;
        rf_acc = '0;
        dm_acc = '0;
        for (int i = 0; i < 32; i++) rf_acc |= dut.RF.memory[i];
        for (int i = 0; i < 64; i++) dm_acc |= dut.DM.mem[i];
        chk({n, "_rf_zero"}, rf_acc, 32'h0);
        chk({n, "_dm_zero"}, dm_acc, 32'h0);
    endtask

    // Called at a negedge with the DUT expected to sit at pc.
    task automatic run_row(input vec_t v, input logic [31:0] pc);
        vec_t e;
        dut.IM.mem[pc[9:2]] = v.insn;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.name, "_pc"}, dut.pc_out, e.npc);
        if (e.kind == K_REG) begin
            chk({e.name, "_rf"}, dut.RF.memory[e.idx], e.val);
        end else if (e.kind == K_MEM) begin
            chk({e.name, "_dm"}, dut.DM.mem[e.idx], e.val);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] pc;
        logic [31:0] lp;

        tbl.push_back(mk("addi_x1", enc_i(5, 0, 0, 1, 'h13),
                         K_REG, 1, 32'd5, 32'h04));
        tbl.push_back(mk("addi_neg", enc_i(-3, 0, 0, 2, 'h13),
                         K_REG, 2, 32'hFFFF_FFFD, 32'h08));
        tbl.push_back(mk("add", enc_r(0, 2, 1, 0, 3),
                         K_REG, 3, 32'd2, 32'h0C));
        tbl.push_back(mk("sub", enc_r('h20, 2, 1, 0, 4),
                         K_REG, 4, 32'd8, 32'h10));
        tbl.push_back(mk("beq_tk", enc_b(8, 1, 1, 0),
                         K_PC, 0, 0, 32'h18));
        tbl.push_back(mk("bne_nt", enc_b(8, 1, 1, 1),
                         K_PC, 0, 0, 32'h1C));
        tbl.push_back(mk("bltu_nt", enc_b(8, 1, 2, 6),
                         K_PC, 0, 0, 32'h20));
        tbl.push_back(mk("jal", enc_j(12, 1),
                         K_REG, 1, 32'h24, 32'h2C));
        tbl.push_back(mk("jalr_odd", enc_i(1, 1, 0, 0, 'h67),
                         K_PC, 0, 0, 32'h24));
        tbl.push_back(mk("blt_tk", enc_b(8, 1, 2, 4),
                         K_PC, 0, 0, 32'h2C));
        tbl.push_back(mk("x0_wr", enc_i(7, 0, 0, 0, 'h13),
                         K_REG, 0, 32'd0, 32'h30));
        tbl.push_back(mk("lui", enc_u('h12345, 5, 'h37),
                         K_REG, 5, 32'h1234_5000, 32'h34));
        tbl.push_back(mk("addi_b30", enc_i('h678, 5, 0, 5, 'h13),
                         K_REG, 5, 32'h1234_5678, 32'h38));
        tbl.push_back(mk("sw", enc_s(8, 5, 0, 2),
                         K_MEM, 2, 32'h1234_5678, 32'h3C));
        tbl.push_back(mk("lw", enc_i(8, 0, 2, 6, 'h03),
                         K_REG, 6, 32'h1234_5678, 32'h40));
        tbl.push_back(mk("lui_1000", enc_u(1, 7, 'h37),
                         K_REG, 7, 32'h0000_1000, 32'h44));
        tbl.push_back(mk("sw_oor", enc_s(0, 5, 7, 2),
                         K_MEM, 0, 32'h0, 32'h48));
        tbl.push_back(mk("addi_x8", enc_i(1, 0, 0, 8, 'h13),
                         K_REG, 8, 32'd1, 32'h4C));
        tbl.push_back(mk("lw_oor", enc_i(0, 7, 2, 8, 'h03),
                         K_REG, 8, 32'd0, 32'h50));
        tbl.push_back(mk("srai", enc_i('h401, 2, 5, 9, 'h13),
                         K_REG, 9, 32'hFFFF_FFFE, 32'h54));
        tbl.push_back(mk("srli", enc_i(28, 2, 5, 10, 'h13),
                         K_REG, 10, 32'h0000_000F, 32'h58));
        tbl.push_back(mk("slt", enc_r(0, 1, 2, 2, 11),
                         K_REG, 11, 32'd1, 32'h5C));
        tbl.push_back(mk("sltu", enc_r(0, 1, 2, 3, 11),
                         K_REG, 11, 32'd0, 32'h60));
        tbl.push_back(mk("xori", enc_i(-1, 1, 4, 12, 'h13),
                         K_REG, 12, 32'hFFFF_FFDB, 32'h64));
        tbl.push_back(mk("auipc", enc_u(1, 13, 'h17),
                         K_REG, 13, 32'h0000_1064, 32'h68));
        tbl.push_back(mk("sll", enc_r(0, 3, 1, 1, 14),
                         K_REG, 14, 32'h0000_0090, 32'h6C));
        tbl.push_back(mk("add_wrap", enc_r(0, 1, 2, 0, 15),
                         K_REG, 15, 32'h0000_0021, 32'h70));
        tbl.push_back(mk("ecall_nop", 32'h0000_0073,
                         K_PC, 0, 0, 32'h74));
        tbl.push_back(mk("bge_back", enc_b(-116, 2, 1, 5),
                         K_PC, 0, 0, 32'h00));
`ifdef MONOCYCLE_BYTE_HALF_EN
        tbl.push_back(mk("addi_80", enc_i('h80, 0, 0, 16, 'h13),
                         K_REG, 16, 32'h80, 32'h04));
        tbl.push_back(mk("sb", enc_s(1, 16, 0, 0),
                         K_MEM, 0, 32'h0000_8000, 32'h08));
        tbl.push_back(mk("lb", enc_i(1, 0, 0, 17, 'h03),
                         K_REG, 17, 32'hFFFF_FF80, 32'h0C));
        tbl.push_back(mk("lbu", enc_i(1, 0, 4, 18, 'h03),
                         K_REG, 18, 32'h0000_0080, 32'h10));
        tbl.push_back(mk("sh", enc_s(2, 5, 0, 1),
                         K_MEM, 0, 32'h5678_8000, 32'h14));
        tbl.push_back(mk("lh_hi", enc_i(2, 0, 1, 19, 'h03),
                         K_REG, 19, 32'h0000_5678, 32'h18));
        tbl.push_back(mk("lh_lo", enc_i(0, 0, 1, 21, 'h03),
                         K_REG, 21, 32'hFFFF_8000, 32'h1C));
        tbl.push_back(mk("lh_odd", enc_i(3, 0, 1, 22, 'h03),
                         K_REG, 22, 32'h0000_5678, 32'h20));
`else
        tbl.push_back(mk("sb_nop", enc_s(1, 5, 0, 0),
                         K_MEM, 0, 32'h0, 32'h04));
`endif

        for (int k = 0; k < 256; k++) dut.IM.mem[k] = NOP_INSN;

        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", dut.pc_out, 32'h0);
        chk_all_zero("rst");
        @(negedge clk);
        rst = 1'b1;

        pc = 32'h0;
        for (int i = 0; i < tbl.size(); i++) begin
            run_row(tbl[i], pc);
            pc = tbl[i].npc;
        end

        // tight loop: x20++ ; jal x0,-4
        lp = pc + 32'd4;
        dut.IM.mem[pc[9:2]] = enc_i(1, 20, 0, 20, 'h13);
        dut.IM.mem[lp[9:2]] = enc_j(-4, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("loop_x20", dut.RF.memory[20], 32'd3);
        chk("pre_rst_dm2", dut.DM.mem[2], 32'h1234_5678);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_pc", dut.pc_out, 32'h0);
        chk("mid_rst_x20", dut.RF.memory[20], 32'h0);
        chk("mid_rst_dm2", dut.DM.mem[2], 32'h0);
        chk_all_zero("mid_rst");

        dut.IM.mem[0] = enc_i(9, 0, 0, 1, 'h13);
        @(posedge clk);
        #1;
        chk("held_pc", dut.pc_out, 32'h0);
        chk("held_no_wr", dut.RF.memory[1], 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("first_pc", dut.pc_out, 32'h4);
        chk("first_x1", dut.RF.memory[1], 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
